// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared geometry, widths and FSM states for the conv window scheduler
package conv_pkg;

  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int K       = 3;
  localparam int OUT_W   = IMG_W - K + 1;
  localparam int OUT_H   = IMG_H - K + 1;
  localparam int NUM_WIN = OUT_W * OUT_H;
  localparam int DW_DEF  = 16;
  localparam int AW_DEF  = 6;
  localparam int PW      = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/conv_pos_counter.sv
// rtl/conv_pos_counter.sv - raster row/col window counter with a running linear result address
module conv_pos_counter
  import conv_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          inc_i,
  output logic [PW-1:0] row_o,
  output logic [PW-1:0] col_o,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  logic [PW-1:0] row_q, row_d;
  logic [PW-1:0] col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          col_last;

  assign col_last = (col_q == PW'(OUT_W - 1));
  assign last_o   = (addr_q == AW'(NUM_WIN - 1));
  assign row_o    = row_q;
  assign col_o    = col_q;
  assign addr_o   = addr_q;

  // The address advances alongside row/col so row*OUT_W+col never needs a multiplier.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (clear_i) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
    end else if (inc_i && !last_o) begin
      addr_d = addr_q + AW'(1);
      if (col_last) begin
        col_d = '0;
        row_d = row_q + PW'(1);
      end else begin
        col_d = col_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - issues 3x3 window requests in raster order and writes results back
module conv_window_scheduler
  import conv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_st,
  input  logic          abort,
  output logic          busy,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [PW-1:0] win_row,
  output logic [PW-1:0] win_col,
  input  logic          res_valid,
  input  logic [DW-1:0] res_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          out_st
);

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] data_q, data_d;
  logic          cnt_clear;
  logic          cnt_inc;
  logic          cnt_last;
  logic          aborting;

  conv_pos_counter #(
    .AW (AW)
  ) u_pos (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .row_o   (win_row),
    .col_o   (win_col),
    .addr_o  (wr_addr),
    .last_o  (cnt_last)
  );

  assign aborting = abort && (state_q != S_IDLE);
  assign busy     = busy_q;
  assign wr_data  = data_q;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    win_valid = 1'b0;
    wr_en     = 1'b0;
    out_st    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_st) begin
          cnt_clear = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        win_valid = 1'b1;
        if (win_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (res_valid) begin
          data_d  = res_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (cnt_last) begin
          state_d = S_DONE;
        end else begin
          cnt_inc = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        out_st  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort suppresses every outward strobe in the cycle it is seen, so nothing leaks.
    if (aborting) begin
      state_d   = S_IDLE;
      data_d    = data_q;
      cnt_inc   = 1'b0;
      win_valid = 1'b0;
      wr_en     = 1'b0;
      out_st    = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb/tb_conv_window_scheduler.sv - self-checking bench for conv_window_scheduler
module tb_conv_window_scheduler;
  import conv_pkg::*;

  localparam int W  = 6;
  localparam int NW = 36;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_st = 1'b0;
  logic        abort = 1'b0;
  logic        win_ready = 1'b1;
  logic        res_valid = 1'b0;
  logic [15:0] res_data = '0;
  logic        busy, win_valid, wr_en, out_st;
  logic [2:0]  win_row, win_col;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;

  always #5 clk = ~clk;

  conv_window_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .in_st     (in_st),
    .abort     (abort),
    .busy      (busy),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_row   (win_row),
    .win_col   (win_col),
    .res_valid (res_valid),
    .res_data  (res_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_st    (out_st)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: windows are numbered 0..35 in raster order.
  int   exp_idx = 0;
  int   wr_idx = 0;
  int   out_cnt = 0;
  int   stall_seen = 0;
  bit   quiet = 1'b0;
  int   seen_at7 = -1;
  int   seen_at8 = -1;
  int   first_addr = -1;
  int   rc18 = -1;
  bit   prev_stall = 1'b0;
  int   prev_pos = 0;

  // Datapath responder knobs
  int lat = 2;
  int stall_idx = -1;
  int stall_left = 0;
  bit inject_issue = 1'b0;
  int abort_idx = -1;
  bit abort_now = 1'b0;
  bit pend = 1'b0;
  int pend_cnt = 0;
  int pend_idx = 0;
  bit hs = 1'b0;
  int hs_idx = 0;

  function automatic logic [15:0] dp_value(int idx);
    if (idx == 7) return 16'h8000;
    if (idx == 8) return 16'h7FFF;
    return 16'((idx * 1237) ^ 32'h3C5A);
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", int'(win_valid), 1);
        check("stall_pos_held", int'({win_row, win_col}), prev_pos);
      end
      if (quiet) begin
        check("quiet_no_wr_en", int'(wr_en), 0);
        check("quiet_no_req", int'(win_valid), 0);
        check("quiet_no_out_st", int'(out_st), 0);
      end else begin
        if (win_valid && win_ready) begin
          check("no_dup_req", exp_idx, wr_idx);
          check("req_row", int'(win_row), exp_idx / W);
          check("req_col", int'(win_col), exp_idx % W);
          if (exp_idx == 18) rc18 = int'({win_row, win_col});
          exp_idx++;
        end
        if (wr_en) begin
          check("wr_addr", int'(wr_addr), wr_idx);
          check("wr_data", int'(wr_data), int'(dp_value(wr_idx)));
          if (first_addr < 0) first_addr = int'(wr_addr);
          if (wr_idx == 7) seen_at7 = int'(wr_data);
          if (wr_idx == 8) seen_at8 = int'(wr_data);
          wr_idx++;
        end
        if (out_st) begin
          check("out_st_after_all", wr_idx, NW);
          out_cnt++;
        end
      end
      if (win_valid && !win_ready && win_row == 3'd2 && win_col == 3'd5) stall_seen++;
      prev_stall = win_valid && !win_ready;
      prev_pos   = int'({win_row, win_col});
    end
  end

  // Datapath model: accepts requests, returns dp_value(idx) after lat cycles.
  initial begin
    forever begin
      @(negedge clk);
      hs     = win_valid && win_ready && !reset;
      hs_idx = int'(win_row) * W + int'(win_col);
      @(posedge clk);
      #1;
      res_valid = 1'b0;
      abort     = 1'b0;
      if (hs) begin
        pend     = 1'b1;
        pend_cnt = lat;
        pend_idx = hs_idx;
      end
      if (abort_now) begin
        abort     = 1'b1;
        quiet     = 1'b1;
        abort_now = 1'b0;
      end else if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          res_valid = 1'b1;
          res_data  = dp_value(pend_idx);
          pend      = 1'b0;
          if (pend_idx == abort_idx) abort_now = 1'b1;
        end
      end else if (inject_issue && win_valid) begin
        res_valid    = 1'b1;
        res_data     = 16'h5A5A;
        inject_issue = 1'b0;
      end
      win_ready = 1'b1;
      if (stall_left > 0 && win_valid && (int'(win_row) * W + int'(win_col)) == stall_idx) begin
        win_ready = 1'b0;
        stall_left--;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame();
    exp_idx    = 0;
    wr_idx     = 0;
    out_cnt    = 0;
    first_addr = -1;
    quiet      = 1'b0;
    in_st      = 1'b1;
    tick(1);
    in_st      = 1'b0;
  endtask

  task automatic wait_done(string name);
    int t;
    t = 0;
    while (out_cnt == 0 && t < 2000) begin
      tick(1);
      t++;
    end
    check({name, "_out_st_once"}, out_cnt, 1);
    @(negedge clk);
    check({name, "_busy_low_after"}, int'(busy), 0);
    check({name, "_writes"}, wr_idx, NW);
  endtask

  initial begin
    int t;
    // Reset values
    reset = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_win_valid", int'(win_valid), 0);
    check("rst_win_row", int'(win_row), 0);
    check("rst_win_col", int'(win_col), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_out_st", int'(out_st), 0);
    tick(1);
    reset = 1'b0;
    tick(2);

    // Full frame, ready=1, 2-cycle result latency, extreme result values
    lat = 2;
    start_frame();
    @(negedge clk);
    check("busy_after_start", int'(busy), 1);
    tick(1);
    wait_done("frame_a");
    check("data_8000_verbatim", seen_at7, 32'h8000);
    check("data_7fff_verbatim", seen_at8, 32'h7FFF);
    check("frame_a_first_addr", first_addr, 0);
    tick(3);
    check("frame_a_single_out_st", out_cnt, 1);

    // Stall on (2,5), in_st during busy, res_valid injected in ISSUE
    stall_idx  = 17;
    stall_left = 5;
    stall_seen = 0;
    rc18       = -1;
    start_frame();
    t = 0;
    while (exp_idx < 10 && t < 500) begin tick(1); t++; end
    check("frame_b_progress", int'(exp_idx >= 10), 1);
    in_st = 1'b1;
    tick(1);
    in_st = 1'b0;
    inject_issue = 1'b1;
    wait_done("frame_b");
    check("stall_cycles", stall_seen, 5);
    check("after_stall_is_3_0", rc18, 32'h18);
    check("inject_consumed", int'(inject_issue), 0);
    stall_idx = -1;
    tick(2);

    // Abort in WRITE of addr 20, then restart
    abort_idx = 20;
    start_frame();
    t = 0;
    while (!quiet && t < 2000) begin tick(1); t++; end
    abort_idx = -1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_win_valid", int'(win_valid), 0);
    check("abort_writes", wr_idx, 20);
    check("abort_no_out_st", out_cnt, 0);
    tick(10);
    start_frame();
    wait_done("restart");
    check("restart_first_addr", first_addr, 0);
    tick(2);

    // Reset while a result is outstanding
    lat = 4;
    start_frame();
    t = 0;
    while (!(pend && exp_idx >= 5) && t < 2000) begin tick(1); t++; end
    check("reached_wait", int'(pend), 1);
    reset = 1'b1;
    quiet = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", int'(busy), 0);
    check("midreset_win_valid", int'(win_valid), 0);
    tick(8);
    check("midreset_no_out_st", out_cnt, 0);
    lat = 2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
